// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming sobel controller.
// Binary edge-map output is selected with SOBEL_THRESH_EN.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  // Window rows (top = two lines back) and stored columns.
  localparam int WIN_TOP = 0;
  localparam int WIN_MID = 1;
  localparam int WIN_BOT = 2;
  localparam int WIN_L   = 0;
  localparam int WIN_C   = 1;

  function automatic pix_t binarise(pix_t mag, int thr);
    return (int'(mag) >= thr) ? '1 : '0;
  endfunction

endpackage

// File: rtl/sobel_filter.sv
// Combinational 3x3 sobel: |Gx| + |Gy|, saturated to 8 bits.
// Pij: i = row (0 top), j = column (0 left).
module sobel_filter
  import sobel_pkg::*;
(
  input  pix_t P00,
  input  pix_t P01,
  input  pix_t P02,
  input  pix_t P10,
  input  pix_t P11,
  input  pix_t P12,
  input  pix_t P20,
  input  pix_t P21,
  input  pix_t P22,
  output pix_t edge_mag
);

  logic [11:0] xp, xn, yp, yn;
  logic [11:0] ax, ay;
  logic [12:0] sum;

  always_comb begin
    xp  = {4'b0, P02} + {3'b0, P12, 1'b0} + {4'b0, P22};
    xn  = {4'b0, P00} + {3'b0, P10, 1'b0} + {4'b0, P20};
    yp  = {4'b0, P20} + {3'b0, P21, 1'b0} + {4'b0, P22};
    yn  = {4'b0, P00} + {3'b0, P01, 1'b0} + {4'b0, P02};
    ax  = (xp >= xn) ? xp - xn : xn - xp;
    ay  = (yp >= yn) ? yp - yn : yn - yp;
    sum = {1'b0, ax} + {1'b0, ay};
    edge_mag = (|sum[12:8]) ? 8'hFF : sum[7:0];
  end

  logic unused;
  assign unused = ^P11;

endmodule

// File: rtl/sobel_line_buffer.sv
// One-row delay line: dout is the pixel written DEPTH shifts ago.
// Circular buffer, so only the pointer needs a reset.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 549
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t           mem [DEPTH];
  logic [AW-1:0]  ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Raster-stream frame controller around sobel_filter.
// Define SOBEL_THRESH_EN for a binary (THRESH) edge map.
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 549,
  parameter int HEIGHT = 319,
  parameter int THRESH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_mag,
  output logic             out_last
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

`ifdef SOBEL_THRESH_EN
  localparam bit BIN = 1'b1;
`else
  localparam bit BIN = 1'b0;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pix_t          lb0_q, lb1_q;
  pix_t          win [3][2];
  pix_t          col_new [3];
  pix_t          edge_mag, res;
  logic          accept, emit, frame_end;

  assign in_ready  = (state == STREAM)
                   && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign frame_end = (row == RW'(HEIGHT - 1))
                   && (col == CW'(WIDTH - 1));
  // Centre lies one row/col behind; borders never emit.
  assign emit      = accept
                   && (row >= RW'(2))
                   && (col >= CW'(2));

  assign busy = (state == STREAM)
             || (state == FLUSH);
  assign done = (state == DONE);

  sobel_line_buffer #(.DEPTH(WIDTH)) u_lb0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .din   (in_pixel),
    .dout  (lb0_q)
  );

  sobel_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .din   (lb0_q),
    .dout  (lb1_q)
  );

  assign col_new[WIN_TOP] = lb1_q;
  assign col_new[WIN_MID] = lb0_q;
  assign col_new[WIN_BOT] = in_pixel;

  sobel_filter u_filt (
    .P00      (win[WIN_TOP][WIN_L]),
    .P01      (win[WIN_TOP][WIN_C]),
    .P02      (col_new[WIN_TOP]),
    .P10      (win[WIN_MID][WIN_L]),
    .P11      (win[WIN_MID][WIN_C]),
    .P12      (col_new[WIN_MID]),
    .P20      (win[WIN_BOT][WIN_L]),
    .P21      (win[WIN_BOT][WIN_C]),
    .P22      (col_new[WIN_BOT]),
    .edge_mag (edge_mag)
  );

  assign res = BIN ? binarise(edge_mag, THRESH)
                   : edge_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        win[r][WIN_L] <= '0;
        win[r][WIN_C] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][WIN_L] <= win[r][WIN_C];
        win[r][WIN_C] <= col_new[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == CW'(WIDTH - 1)) begin
        col <= '0;
        row <= frame_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_mag   <= res;
      out_last  <= frame_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = STREAM;
      STREAM: if (accept && frame_end) state_nxt = FLUSH;
      FLUSH:  if (!out_valid || out_ready) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Randomised bench for sobel_stream_ctrl on a 5x4 frame
// against a direct 3x3 sobel reference model.
module tb_sobel_stream_ctrl;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int TH = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic       busy, done, in_ready, out_valid, out_last;
  logic [7:0] out_mag;

  int checks = 0;
  int passes = 0;

  int   img [N];
  int   exp_q [$];
  int   got_mag [$];
  bit   got_last [$];
  bit   timeout;
  logic done_a, done_b;
  int   stall_bad, busy_bad;

  sobel_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .THRESH(TH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic int px(int r, int c);
    return img[r * W + c];
  endfunction

  function automatic int model(int r, int c);
    int gx, gy, m;
    gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1))
       - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
    gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1))
       - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
    m = (m >= TH) ? 255 : 0;
`endif
    return m;
  endfunction

  task automatic build_exp();
    exp_q.delete();
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++)
        exp_q.push_back(model(r, c));
  endtask

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int rdy_pct, input int gap_pct,
                           input int spur);
    int idx = 0;
    int cyc = 0;
    bit fin = 0;
    got_mag.delete();
    got_last.delete();
    timeout = 0;
    stall_bad = 0;
    busy_bad = 0;
    while (!fin) begin
      @(negedge clk);
      in_valid  = (idx < N) && ($urandom_range(99) >= gap_pct);
      in_pixel  = in_valid ? 8'(img[idx]) : 8'h00;
      out_ready = ($urandom_range(99) < rdy_pct);
      start     = (idx == spur);
      #1;
      if (busy !== 1'b1) busy_bad++;
      if (out_valid && !out_ready && in_ready) stall_bad++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got_mag.push_back(int'(out_mag));
        got_last.push_back(out_last);
        if (out_last) fin = 1;
      end
      cyc++;
      if (cyc > 2000) begin
        timeout = 1;
        fin = 1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    #1 done_a = done;
    @(negedge clk);
    #1 done_b = done;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, in_ready, out_valid, out_last, out_mag} !== 13'd0)
      $display("FAIL reset_outputs got=%b want=0",
               {busy, done, in_ready, out_valid, out_last, out_mag});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL reset_release busy=%b in_ready=%b want 0/0",
               busy, in_ready);
    else passes++;
  endtask

  task automatic test_flat();
    foreach (img[i]) img[i] = 8'h40;
    build_exp();
    start_frame();
    run_frame(100, 0, -1);
    checks++;
    if (timeout || got_mag.size() != 6)
      $display("FAIL flat_count got=%0d want=6 timeout=%0d",
               got_mag.size(), timeout);
    else passes++;
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_mag.size() || got_mag[i] != 0
          || got_last[i] != (i == 5))
        $display("FAIL flat_res%0d got=%0d want=0", i,
                 i < got_mag.size() ? got_mag[i] : -1);
      else passes++;
    end
    checks++;
    if (done_a !== 1'b1 || done_b !== 1'b0)
      $display("FAIL flat_done got=%b%b want=10", done_a, done_b);
    else passes++;
  endtask

  task automatic test_step();
    foreach (img[i]) img[i] = ((i % W) >= 2) ? 255 : 0;
    build_exp();
    start_frame();
    run_frame(100, 0, -1);
    checks++;
    if (timeout || got_mag.size() != exp_q.size())
      $display("FAIL step_count got=%0d want=%0d timeout=%0d",
               got_mag.size(), exp_q.size(), timeout);
    else passes++;
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_mag.size() || got_mag[i] != exp_q[i]
          || got_mag[i] != (((i % 3) < 2) ? 255 : 0))
        $display("FAIL step_res%0d got=%0d want=%0d", i,
                 i < got_mag.size() ? got_mag[i] : -1, exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_random_backpressure();
    for (int k = 0; k < 3; k++) begin
      foreach (img[i]) img[i] = int'($urandom_range(255));
      build_exp();
      start_frame();
      run_frame(50, 30, -1);
      checks++;
      if (timeout || got_mag.size() != exp_q.size() || stall_bad != 0)
        $display("FAIL rand_count got=%0d want=%0d stall=%0d",
                 got_mag.size(), exp_q.size(), stall_bad);
      else passes++;
      foreach (exp_q[i]) begin
        checks++;
        if (i >= got_mag.size() || got_mag[i] != exp_q[i]
            || got_last[i] != (i == exp_q.size() - 1))
          $display("FAIL rand_res%0d got=%0d want=%0d", i,
                   i < got_mag.size() ? got_mag[i] : -1, exp_q[i]);
        else passes++;
      end
      checks++;
      if (done_a !== 1'b1 || done_b !== 1'b0)
        $display("FAIL rand_done got=%b%b want=10", done_a, done_b);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    int cyc = 0;
    start_frame();
    while (cnt < 9 && cyc < 50) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_pixel = 8'($urandom_range(255));
      out_ready = 1'b0;
      #1;
      if (in_ready) cnt++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cnt != 9 || busy !== 1'b0 || in_ready !== 1'b0
        || out_valid !== 1'b0)
      $display("FAIL midrst_state cnt=%0d busy=%b in_ready=%b ov=%b",
               cnt, busy, in_ready, out_valid);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    foreach (img[i]) img[i] = int'($urandom_range(255));
    build_exp();
    start_frame();
    run_frame(100, 0, -1);
    checks++;
    if (timeout || got_mag.size() != 6)
      $display("FAIL midrst_count got=%0d want=6", got_mag.size());
    else passes++;
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_mag.size() || got_mag[i] != exp_q[i])
        $display("FAIL midrst_res%0d got=%0d want=%0d", i,
                 i < got_mag.size() ? got_mag[i] : -1, exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_ignore();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_pixel = 8'($urandom_range(255));
      #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0)
        $display("FAIL idle_in got in_ready=%b busy=%b want 0/0",
                 in_ready, busy);
      else passes++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    foreach (img[i]) img[i] = int'($urandom_range(255));
    build_exp();
    start_frame();
    run_frame(70, 10, 7);
    checks++;
    if (timeout || busy_bad != 0 || got_mag.size() != exp_q.size())
      $display("FAIL spur_start busy_bad=%0d got=%0d want=%0d",
               busy_bad, got_mag.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_mag.size() || got_mag[i] != exp_q[i])
        $display("FAIL spur_res%0d got=%0d want=%0d", i,
                 i < got_mag.size() ? got_mag[i] : -1, exp_q[i]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step();
    test_random_backpressure();
    test_reset_mid();
    test_ignore();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
